// File: rtl/fec_pkg.sv
// Shared FEC definitions: CRC mode and state types plus the CRC0/CRC1 profile parameters.
package fec_pkg;

    typedef enum bit {CRC_GEN = 1'b0, CRC_CHECK = 1'b1} crc_mode_t;

    typedef enum logic [1:0] {
        CRC_ST_IDLE = 2'd0,
        CRC_ST_BUSY = 2'd1,
        CRC_ST_DONE = 2'd2
    } crc_state_t;

    // CRC0: 8-bit CRC over a 56-bit word, x^8 + x^2 + x + 1
    localparam int unsigned    CRC0_DATA_WIDTH        = 56;
    localparam int unsigned    CRC0_CRC_WIDTH         = 8;
    localparam logic [8:0]     CRC0_POLY              = 9'b100000111;
    localparam logic [7:0]     CRC0_SEED              = 8'h00;
    localparam int unsigned    CRC0_XOR_OPS_PER_CYCLE = 8;
    localparam int unsigned    CRC0_CYCLES            = CRC0_DATA_WIDTH / CRC0_XOR_OPS_PER_CYCLE;

    // CRC1: 4-bit CRC over a 12-bit word, x^4 + x + 1
    localparam int unsigned    CRC1_DATA_WIDTH        = 12;
    localparam int unsigned    CRC1_CRC_WIDTH         = 4;
    localparam logic [4:0]     CRC1_POLY              = 5'b10011;
    localparam logic [3:0]     CRC1_SEED              = 4'h0;
    localparam int unsigned    CRC1_XOR_OPS_PER_CYCLE = 4;
    localparam int unsigned    CRC1_CYCLES            = CRC1_DATA_WIDTH / CRC1_XOR_OPS_PER_CYCLE;

endpackage

// File: rtl/fec_crc_step.sv
// Combinational CRC update over BITS_PER_CYCLE data bits, MSB first (unrolled bit-serial step).
module fec_crc_step #(
    parameter int unsigned           CRC_WIDTH      = 8,
    parameter logic [CRC_WIDTH:0]    POLY           = 9'b100000111,
    parameter int unsigned           BITS_PER_CYCLE = 8
) (
    input  logic [CRC_WIDTH-1:0]      crc_i,
    input  logic [BITS_PER_CYCLE-1:0] data_i,
    output logic [CRC_WIDTH-1:0]      crc_o
);

    // The x^CRC_WIDTH term is implicit in the shift-out of the top bit.
    localparam logic [CRC_WIDTH-1:0] TAPS = POLY[CRC_WIDTH-1:0];

    logic [CRC_WIDTH-1:0] crc_v;

    always_comb begin
        crc_v = crc_i;
        for (int i = int'(BITS_PER_CYCLE) - 1; i >= 0; i--) begin
            if (crc_v[CRC_WIDTH-1] ^ data_i[i]) begin
                crc_v = {crc_v[CRC_WIDTH-2:0], 1'b0} ^ TAPS;
            end else begin
                crc_v = {crc_v[CRC_WIDTH-2:0], 1'b0};
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/fec_crc_engine.sv
// Multi-bit-per-cycle CRC engine: generates the CRC of a word, or checks it against a received CRC.
module fec_crc_engine
    import fec_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 56,
    parameter int unsigned           CRC_WIDTH      = 8,
    parameter logic [CRC_WIDTH:0]    POLY           = 9'b100000111,
    parameter logic [CRC_WIDTH-1:0]  SEED           = '0,
    parameter int unsigned           BITS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  crc_mode_t             s_mode_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [CRC_WIDTH-1:0]  s_crc_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CRC_WIDTH-1:0]  m_crc_o,
    output logic                  m_err_o,
    output logic                  busy_o
);

    localparam int unsigned      N        = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned      CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("fec_crc_engine: DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    crc_state_t            state_q, state_d;
    logic                  accept, finish;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CRC_WIDTH-1:0]  crc_q, crc_step, ref_crc_q;
    crc_mode_t             mode_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  m_valid_q, m_err_q;
    logic [CRC_WIDTH-1:0]  m_crc_q;

    fec_crc_step #(
        .CRC_WIDTH      (CRC_WIDTH),
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (shift_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
        .crc_o  (crc_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CRC_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; clear_i overrides everything
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        if (clear_i) begin
            state_d = CRC_ST_IDLE;
        end else begin
            case (state_q)
                CRC_ST_IDLE: begin
                    if (s_valid_i) begin
                        accept  = 1'b1;
                        state_d = CRC_ST_BUSY;
                    end
                end
                CRC_ST_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        finish  = 1'b1;
                        state_d = CRC_ST_DONE;
                    end
                end
                CRC_ST_DONE: begin
                    if (m_ready_i) begin
                        state_d = CRC_ST_IDLE;
                    end
                end
                default: state_d = CRC_ST_IDLE;
            endcase
        end
    end

    // Datapath: latch request on acceptance, then consume one chunk per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            crc_q     <= SEED;
            cnt_q     <= '0;
            mode_q    <= CRC_GEN;
            ref_crc_q <= '0;
        end else if (accept) begin
            shift_q   <= s_data_i;
            crc_q     <= SEED;
            cnt_q     <= '0;
            mode_q    <= s_mode_i;
            ref_crc_q <= s_crc_i;
        end else if ((state_q == CRC_ST_BUSY) && !clear_i) begin
            shift_q   <= shift_q << BITS_PER_CYCLE;
            crc_q     <= crc_step;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers; crc/err hold their last value across clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_crc_q   <= '0;
            m_err_q   <= 1'b0;
        end else begin
            m_valid_q <= (state_d == CRC_ST_DONE);
            if (finish) begin
                m_crc_q <= crc_step;
                m_err_q <= (mode_q == CRC_CHECK) && (crc_step != ref_crc_q);
            end
        end
    end

    assign s_ready_o = (state_q == CRC_ST_IDLE);
    assign busy_o    = (state_q == CRC_ST_BUSY);
    assign m_valid_o = m_valid_q;
    assign m_crc_o   = m_crc_q;
    assign m_err_o   = m_err_q;

endmodule

// File: tb/tb_fec_crc_engine.sv
// Self-checking bench for fec_crc_engine: CRC0 and CRC1 profiles against a polynomial-division model.
module tb_fec_crc_engine;
    import fec_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // CRC0 instance signals
    logic        c0_clear, c0_s_valid, c0_s_ready, c0_m_valid, c0_m_ready, c0_m_err, c0_busy;
    crc_mode_t   c0_mode;
    logic [55:0] c0_data;
    logic [7:0]  c0_s_crc, c0_m_crc;

    // CRC1 instance signals
    logic        c1_clear, c1_s_valid, c1_s_ready, c1_m_valid, c1_m_ready, c1_m_err, c1_busy;
    crc_mode_t   c1_mode;
    logic [11:0] c1_data;
    logic [3:0]  c1_s_crc, c1_m_crc;

    fec_crc_engine #(
        .DATA_WIDTH(CRC0_DATA_WIDTH), .CRC_WIDTH(CRC0_CRC_WIDTH), .POLY(CRC0_POLY),
        .SEED(CRC0_SEED), .BITS_PER_CYCLE(CRC0_XOR_OPS_PER_CYCLE)
    ) u_crc0 (
        .clk(clk), .rst_n(rst_n), .clear_i(c0_clear), .s_valid_i(c0_s_valid),
        .s_ready_o(c0_s_ready), .s_mode_i(c0_mode), .s_data_i(c0_data), .s_crc_i(c0_s_crc),
        .m_valid_o(c0_m_valid), .m_ready_i(c0_m_ready), .m_crc_o(c0_m_crc),
        .m_err_o(c0_m_err), .busy_o(c0_busy)
    );

    fec_crc_engine #(
        .DATA_WIDTH(CRC1_DATA_WIDTH), .CRC_WIDTH(CRC1_CRC_WIDTH), .POLY(CRC1_POLY),
        .SEED(CRC1_SEED), .BITS_PER_CYCLE(CRC1_XOR_OPS_PER_CYCLE)
    ) u_crc1 (
        .clk(clk), .rst_n(rst_n), .clear_i(c1_clear), .s_valid_i(c1_s_valid),
        .s_ready_o(c1_s_ready), .s_mode_i(c1_mode), .s_data_i(c1_data), .s_crc_i(c1_s_crc),
        .m_valid_o(c1_m_valid), .m_ready_i(c1_m_ready), .m_crc_o(c1_m_crc),
        .m_err_o(c1_m_err), .busy_o(c1_busy)
    );

    // Reference: remainder of D(x)*x^cw divided by G(x) (zero seed, no reflection, no final XOR)
    function automatic logic [7:0] model_crc(input logic [63:0] data, input int dw,
                                             input logic [8:0] poly, input int cw);
        logic [127:0] r;
        logic [7:0]   mask;
        r = 128'(data) << cw;
        for (int i = dw + cw - 1; i >= cw; i--) begin
            if (r[i]) r = r ^ (128'(poly) << (i - cw));
        end
        mask = 8'((1 << cw) - 1);
        return r[7:0] & mask;
    endfunction

    // Drive one CRC0 request, wait (bounded) for the result, then consume it
    task automatic c0_txn(input bit mode, input logic [55:0] d, input logic [7:0] rc,
                          output int lat, output int busy_cnt,
                          output logic [7:0] crc, output logic err);
        @(negedge clk);
        c0_s_valid = 1'b1; c0_mode = crc_mode_t'(mode); c0_data = d; c0_s_crc = rc;
        @(posedge clk); #1;
        c0_s_valid = 1'b0;
        lat = 0; busy_cnt = 0;
        while (lat < 64 && !c0_m_valid) begin
            if (c0_busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        crc = c0_m_crc; err = c0_m_err;
        @(negedge clk); c0_m_ready = 1'b1;
        @(posedge clk); #1; c0_m_ready = 1'b0;
    endtask

    task automatic c1_txn(input bit mode, input logic [11:0] d, input logic [3:0] rc,
                          output int lat, output int busy_cnt,
                          output logic [3:0] crc, output logic err);
        @(negedge clk);
        c1_s_valid = 1'b1; c1_mode = crc_mode_t'(mode); c1_data = d; c1_s_crc = rc;
        @(posedge clk); #1;
        c1_s_valid = 1'b0;
        lat = 0; busy_cnt = 0;
        while (lat < 64 && !c1_m_valid) begin
            if (c1_busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        crc = c1_m_crc; err = c1_m_err;
        @(negedge clk); c1_m_ready = 1'b1;
        @(posedge clk); #1; c1_m_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({c0_s_ready, c0_m_valid, c0_m_crc, c0_m_err, c0_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_crc0: rdy=%b vld=%b crc=%h err=%b busy=%b, expected 1 0 00 0 0",
                     c0_s_ready, c0_m_valid, c0_m_crc, c0_m_err, c0_busy);
        end
        n_tests++;
        if ({c1_s_ready, c1_m_valid, c1_m_crc, c1_m_err, c1_busy} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_crc1: rdy=%b vld=%b crc=%h err=%b busy=%b, expected 1 0 0 0 0",
                     c1_s_ready, c1_m_valid, c1_m_crc, c1_m_err, c1_busy);
        end
    endtask

    task automatic test_crc0_directed();
        int lat, bc; logic [7:0] crc; logic err;
        c0_txn(1'b0, 56'h0, 8'h00, lat, bc, crc, err);
        n_tests++;
        if ({lat, bc} !== {32'd7, 32'd7}) begin
            n_fail++; $display("FAIL crc0_latency: lat=%0d busy=%0d, expected 7 7", lat, bc);
        end
        n_tests++;
        if ({crc, err} !== {8'h00, 1'b0}) begin
            n_fail++; $display("FAIL crc0_gen_zero: crc=%h err=%b, expected 00 0", crc, err);
        end
        c0_txn(1'b0, 56'h1, 8'h00, lat, bc, crc, err);
        n_tests++;
        if ({crc, err} !== {8'h07, 1'b0}) begin
            n_fail++; $display("FAIL crc0_gen_one: crc=%h err=%b, expected 07 0", crc, err);
        end
        c0_txn(1'b1, 56'h1, 8'h07, lat, bc, crc, err);
        n_tests++;
        if ({crc, err} !== {8'h07, 1'b0}) begin
            n_fail++; $display("FAIL crc0_check_ok: crc=%h err=%b, expected 07 0", crc, err);
        end
        c0_txn(1'b1, 56'h1, 8'h06, lat, bc, crc, err);
        n_tests++;
        if ({crc, err} !== {8'h07, 1'b1}) begin
            n_fail++; $display("FAIL crc0_check_bad: crc=%h err=%b, expected 07 1", crc, err);
        end
        // Error flag is suppressed in generate mode even with a mismatching s_crc_i
        c0_txn(1'b0, 56'h1, 8'hA5, lat, bc, crc, err);
        n_tests++;
        if ({crc, err} !== {8'h07, 1'b0}) begin
            n_fail++; $display("FAIL crc0_gen_no_err: crc=%h err=%b, expected 07 0", crc, err);
        end
    endtask

    task automatic test_crc1_directed();
        int lat, bc; logic [3:0] crc; logic err;
        c1_txn(1'b0, 12'h001, 4'h0, lat, bc, crc, err);
        n_tests++;
        if ({lat, bc, crc} !== {32'd3, 32'd3, 4'h3}) begin
            n_fail++; $display("FAIL crc1_one: lat=%0d busy=%0d crc=%h, expected 3 3 3", lat, bc, crc);
        end
        c1_txn(1'b0, 12'h002, 4'h0, lat, bc, crc, err);
        n_tests++;
        if ({crc, err} !== {4'h6, 1'b0}) begin
            n_fail++; $display("FAIL crc1_two: crc=%h err=%b, expected 6 0", crc, err);
        end
        for (int i = 0; i < 10; i++) begin
            logic [11:0] d; logic [3:0] rc, exp; bit mode;
            d = 12'($urandom); mode = 1'($urandom_range(0, 1));
            exp = 4'(model_crc(64'(d), 12, 9'(CRC1_POLY), 4));
            rc = ($urandom_range(0, 1) != 0) ? exp : 4'($urandom);
            c1_txn(mode, d, rc, lat, bc, crc, err);
            n_tests++;
            if ({crc, err} !== {exp, mode && (exp != rc)}) begin
                n_fail++;
                $display("FAIL crc1_random: d=%h mode=%0d rc=%h got crc=%h err=%b, expected %h %b",
                         d, mode, rc, crc, err, exp, mode && (exp != rc));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [55:0] d; logic [7:0] rc, exp; logic exp_err; int lat;
        d = {24'($urandom), 32'($urandom)};
        exp = model_crc(64'(d), 56, CRC0_POLY, 8);
        rc = exp ^ 8'h10;
        exp_err = 1'b1;
        @(negedge clk);
        c0_s_valid = 1'b1; c0_mode = CRC_CHECK; c0_data = d; c0_s_crc = rc;
        @(posedge clk); #1; c0_s_valid = 1'b0;
        lat = 0;
        while (lat < 64 && !c0_m_valid) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if ({c0_m_valid, c0_m_crc, c0_m_err} !== {1'b1, exp, exp_err}) begin
            n_fail++;
            $display("FAIL bp_result: vld=%b crc=%h err=%b, expected 1 %h %b", c0_m_valid, c0_m_crc, c0_m_err, exp, exp_err);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({c0_m_valid, c0_m_crc, c0_m_err, c0_s_ready} !== {1'b1, exp, exp_err, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: vld=%b crc=%h err=%b rdy=%b, expected 1 %h %b 0",
                         i, c0_m_valid, c0_m_crc, c0_m_err, c0_s_ready, exp, exp_err);
            end
        end
        @(negedge clk); c0_m_ready = 1'b1;
        @(posedge clk); #1; c0_m_ready = 1'b0;
        n_tests++;
        if ({c0_s_ready, c0_m_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release: rdy=%b vld=%b, expected 1 0", c0_s_ready, c0_m_valid);
        end
    endtask

    task automatic test_clear();
        logic [7:0] crc_before; logic err_before, saw_valid;
        int lat, bc; logic [7:0] crc; logic err;
        crc_before = c0_m_crc; err_before = c0_m_err;
        @(negedge clk);
        c0_s_valid = 1'b1; c0_mode = CRC_GEN; c0_data = 56'h1; c0_s_crc = 8'h00;
        @(posedge clk); #1; c0_s_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); c0_clear = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({c0_s_ready, c0_busy, c0_m_valid, c0_m_crc, c0_m_err} !== {1'b1, 1'b0, 1'b0, crc_before, err_before}) begin
            n_fail++;
            $display("FAIL clear_busy: rdy=%b busy=%b vld=%b crc=%h err=%b, expected 1 0 0 %h %b",
                     c0_s_ready, c0_busy, c0_m_valid, c0_m_crc, c0_m_err, crc_before, err_before);
        end
        @(negedge clk); c0_clear = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (c0_m_valid) saw_valid = 1'b1;
        end
        n_tests++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_no_valid: m_valid rose=%b, expected 0", saw_valid);
        end
        // A request coinciding with clear_i must be ignored
        @(negedge clk);
        c0_clear = 1'b1; c0_s_valid = 1'b1; c0_data = 56'h1;
        @(posedge clk); #1;
        c0_clear = 1'b0; c0_s_valid = 1'b0;
        n_tests++;
        if ({c0_s_ready, c0_busy} !== 2'b10) begin
            n_fail++; $display("FAIL clear_blocks_accept: rdy=%b busy=%b, expected 1 0", c0_s_ready, c0_busy);
        end
        c0_txn(1'b0, 56'h1, 8'h00, lat, bc, crc, err);
        n_tests++;
        if ({lat, crc, err} !== {32'd7, 8'h07, 1'b0}) begin
            n_fail++; $display("FAIL clear_recover: lat=%0d crc=%h err=%b, expected 7 07 0", lat, crc, err);
        end
    endtask

    task automatic test_reset_in_done();
        int lat;
        @(negedge clk);
        c0_s_valid = 1'b1; c0_mode = CRC_CHECK; c0_data = 56'h1; c0_s_crc = 8'h06;
        @(posedge clk); #1; c0_s_valid = 1'b0;
        lat = 0;
        while (lat < 64 && !c0_m_valid) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if ({c0_m_valid, c0_m_crc, c0_m_err} !== {1'b1, 8'h07, 1'b1}) begin
            n_fail++; $display("FAIL rst_pre: vld=%b crc=%h err=%b, expected 1 07 1", c0_m_valid, c0_m_crc, c0_m_err);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({c0_s_ready, c0_m_valid, c0_m_crc, c0_m_err, c0_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async: rdy=%b vld=%b crc=%h err=%b busy=%b, expected 1 0 00 0 0",
                     c0_s_ready, c0_m_valid, c0_m_crc, c0_m_err, c0_busy);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        c0_m_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [55:0] d; logic [7:0] rc, exp; bit mode;
            d = {24'($urandom), 32'($urandom)};
            if (i == 0) d = '1;
            mode = 1'($urandom_range(0, 1));
            exp = model_crc(64'(d), 56, CRC0_POLY, 8);
            rc = ($urandom_range(0, 1) != 0) ? exp : 8'($urandom);
            @(negedge clk);
            c0_s_valid = 1'b1; c0_mode = crc_mode_t'(mode); c0_data = d; c0_s_crc = rc;
            @(posedge clk); #1; c0_s_valid = 1'b0;
            lat = 0;
            while (lat < 64 && !c0_m_valid) begin @(posedge clk); #1; lat++; end
            n_tests++;
            if ({lat, c0_m_crc, c0_m_err} !== {32'd7, exp, mode && (exp != rc)}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: d=%h mode=%0d rc=%h got lat=%0d crc=%h err=%b, expected 7 %h %b",
                         i, d, mode, rc, lat, c0_m_crc, c0_m_err, exp, mode && (exp != rc));
            end
            @(posedge clk); #1;
            n_tests++;
            if ({c0_s_ready, c0_m_valid} !== 2'b10) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: rdy=%b vld=%b, expected 1 0", i, c0_s_ready, c0_m_valid);
            end
        end
        c0_m_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        c0_clear = 1'b0; c0_s_valid = 1'b0; c0_m_ready = 1'b0; c0_mode = CRC_GEN; c0_data = '0; c0_s_crc = '0;
        c1_clear = 1'b0; c1_s_valid = 1'b0; c1_m_ready = 1'b0; c1_mode = CRC_GEN; c1_data = '0; c1_s_crc = '0;
        #23;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_crc0_directed();
        test_crc1_directed();
        test_backpressure();
        test_clear();
        test_reset_in_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
